hybrid_control_hyst: RTL and testbench
======================================

// Module: hybrid_control_hyst
// PURPOSE
//  Parametrised hybrid (half-plane jump set) controller for the resonant converter.
//  Computes z1=MU_Z1*vC - s*VG (s=+1 if sigma=1, -1 if sigma=0), z2=MU_Z2*iC, jump=z1*sin+z2*cos.
//  Decides sigma through a hysteresis band and a minimum-dwell lockout, all pipelined.
//  Sits between ADC sample front-end / trigonometry and the gate-drive / dead-time stage.
// PARAMETERS
//  W_IN      14      signed width of i_vC, i_iC
//  W_TRIG    16      signed width of i_cos/i_sin; 1.0 = 2^(W_TRIG-2)
//  MU_Z1     110     z1 gain (voltage)
//  MU_Z2     121     z2 gain (current, includes sqrt(L/C))
//  VG        240000  input voltage in z1 units
//  HYST      0       half-width of hysteresis band on jump (>=0, jump units after shift)
//  MIN_DWELL 8       min clocks sigma is held after a toggle (0 = no lockout)
//  SIGMA_RST 1       sigma value at reset / while disabled
// PORTS
//  i_clock   in  1       system clock
//  i_RESET   in  1       asynchronous, active-low reset
//  i_enable  in  1       1 = run; 0 = force IDLE
//  i_valid   in  1       sample strobe for i_vC/i_iC/i_cos/i_sin
//  i_vC      in  W_IN    signed, z1-related measurement
//  i_iC      in  W_IN    signed, z2-related measurement
//  i_cos     in  W_TRIG  signed cos(theta) from trigonometry
//  i_sin     in  W_TRIG  signed sin(theta)
//  o_sigma   out 1       switching variable
//  o_switch  out 1       1-clock pulse on every sigma toggle
//  o_locked  out 1       1 while dwell lockout active
//  o_valid   out 1       decision for a sample made this cycle
//  o_jump    out 32      signed jump of last decided sample (debug), saturated
// BEHAVIOUR
//  Reset (async, i_RESET=0): o_sigma=SIGMA_RST, o_switch=0, o_locked=0, o_valid=0, o_jump=0,
//   pipeline valids cleared, dwell counter=0, FSM=IDLE. Release synchronous to i_clock.
//  Pipeline: S0 register inputs on i_valid; S1 z1,z2 (z1 uses o_sigma at S1 time);
//   S2 jump_full=z1*sin+z2*cos (full precision, >=W_IN+W_TRIG+20 bits), jump=jump_full>>>(W_TRIG-2);
//   S3 decision. o_valid asserts exactly 3 clocks after i_valid; one result per strobe, back-to-back OK.
//  o_jump: jump saturated to [-2^31, 2^31-1]; decision uses unsaturated value.
//  FSM states IDLE, ON(sigma=1), OFF(sigma=0):
//   IDLE: sigma=SIGMA_RST; -> ON/OFF per SIGMA_RST when i_enable=1; S0-S2 valids flushed on entry.
//   ON : decided sample with jump >  +HYST and counter==0 -> OFF, toggle.
//   OFF: decided sample with jump <  -HYST and counter==0 -> ON, toggle.
//   |jump|<=HYST or jump==+/-HYST: hold. Any state with i_enable=0 -> IDLE next clock (no o_switch).
//  Toggle: o_switch=1 same clock sigma changes; counter loads MIN_DWELL; o_locked=(counter!=0);
//   counter decrements every clock to 0. Requests during lockout are dropped, not queued.
//  Simultaneous: toggle request on the clock counter reaches 0 is honoured; i_enable=0 wins over toggle.
//  S1 uses sigma value registered at S1 clock (no forwarding of in-flight decisions).
// STRUCTURE
//  Shared package hc_pkg: FSM state encodings (IDLE/ON/OFF), jump width, sat helper constants.
//  One sub-module: hc_dwell_fsm (state, counter, o_sigma/o_switch/o_locked); datapath stays top-level.
//  Sin/cos come from existing trigonometry block upstream; not instantiated here.
// TESTING
//  1 Reset: i_RESET=0 mid-run -> o_sigma=1, o_valid=0, o_locked=0 immediately, no o_switch.
//  2 Latency: theta=0 (cos=16384, sin=0), iC=+100, i_valid 1 clk -> o_valid 3 clks later,
//    o_jump=12100, sigma 1->0 with o_switch pulse.
//  3 Hysteresis HYST=5000: jump=+4000 while ON -> hold; jump=+6000 -> OFF; jump=-4000 -> hold.
//  4 Dwell MIN_DWELL=8: toggle then opposite-sign samples each clk -> no toggle for 8 clks,
//    toggle on first sample decided with counter==0; o_locked high exactly 8 clks.
//  5 Enable: i_enable=0 while OFF -> IDLE, sigma=1, no o_switch; samples in flight produce no o_valid.
//  6 Saturation: vC=-8192, iC=-8192, theta=-45deg, VG term -> o_jump=-2^31 clamp, sigma decision correct sign.

Source files
------------

// File: rtl/hc_pkg.sv
// Shared types and constants for the hybrid half-plane controller:
// FSM state encoding, datapath widths and the 32-bit jump saturation helper.
package hc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ON   = 2'd1,
        ST_OFF  = 2'd2
    } hc_state_e;

    localparam int Z_W    = 46;
    localparam int JUMP_W = 64;
    localparam int OUT_W  = 32;

    localparam logic signed [JUMP_W-1:0] SAT_MAX = 64'sd2147483647;
    localparam logic signed [JUMP_W-1:0] SAT_MIN = -64'sd2147483648;
    localparam logic signed [OUT_W-1:0]  OUT_MAX = 32'sh7FFF_FFFF;
    localparam logic signed [OUT_W-1:0]  OUT_MIN = 32'sh8000_0000;

    function automatic logic signed [OUT_W-1:0] sat_jump(input logic signed [JUMP_W-1:0] x);
        if (x > SAT_MAX) begin
            return OUT_MAX;
        end else if (x < SAT_MIN) begin
            return OUT_MIN;
        end else begin
            return $signed(x[OUT_W-1:0]);
        end
    endfunction

endpackage

// File: rtl/hc_dwell_fsm.sv
// Sigma decision FSM with minimum-dwell lockout: turns decided half-plane
// requests into sigma toggles, drops requests while the dwell counter runs.
module hc_dwell_fsm
    import hc_pkg::*;
#(
    parameter int MIN_DWELL = 8,
    parameter int SIGMA_RST = 1
) (
    input  logic      i_clock,
    input  logic      i_RESET,
    input  logic      i_enable,
    input  logic      i_dec_valid,
    input  logic      i_req_pos,
    input  logic      i_req_neg,
    output logic      o_sigma,
    output logic      o_switch,
    output logic      o_locked,
    output hc_state_e o_state
);

    localparam int              CW        = (MIN_DWELL < 1) ? 1 : $clog2(MIN_DWELL + 1);
    localparam logic [CW-1:0]   DWELL_LD  = CW'(MIN_DWELL);
    localparam logic            SIGMA_BIT = (SIGMA_RST != 0);
    localparam hc_state_e       RUN_ST    = (SIGMA_RST != 0) ? ST_ON : ST_OFF;

    hc_state_e       r_state;
    hc_state_e       w_state_nx;
    logic [CW-1:0]   r_cnt;
    logic [CW-1:0]   w_cnt_nx;
    logic            r_switch;
    logic            w_switch_nx;

    always_ff @(posedge i_clock or negedge i_RESET) begin
        if (!i_RESET) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_switch <= 1'b0;
        end else begin
            r_state  <= w_state_nx;
            r_cnt    <= w_cnt_nx;
            r_switch <= w_switch_nx;
        end
    end

    // Disable wins over any toggle and clears the lockout without a switch pulse.
    always_comb begin
        w_state_nx  = r_state;
        w_cnt_nx    = (r_cnt != '0) ? (r_cnt - CW'(1)) : '0;
        w_switch_nx = 1'b0;
        if (!i_enable) begin
            w_state_nx = ST_IDLE;
            w_cnt_nx   = '0;
        end else begin
            case (r_state)
                ST_IDLE: w_state_nx = RUN_ST;
                ST_ON: begin
                    if (i_dec_valid && i_req_pos && (r_cnt == '0)) begin
                        w_state_nx  = ST_OFF;
                        w_cnt_nx    = DWELL_LD;
                        w_switch_nx = 1'b1;
                    end
                end
                ST_OFF: begin
                    if (i_dec_valid && i_req_neg && (r_cnt == '0)) begin
                        w_state_nx  = ST_ON;
                        w_cnt_nx    = DWELL_LD;
                        w_switch_nx = 1'b1;
                    end
                end
                default: w_state_nx = ST_IDLE;
            endcase
        end
    end

    assign o_sigma  = (r_state == ST_ON) | ((r_state == ST_IDLE) & SIGMA_BIT);
    assign o_switch = r_switch;
    assign o_locked = (r_cnt != '0);
    assign o_state  = r_state;

endmodule

// File: rtl/hybrid_control_hyst.sv
// Hybrid half-plane jump-set controller: 3-stage z1/z2/jump datapath feeding
// the hysteresis decision and the dwell-lockout FSM that owns sigma.
module hybrid_control_hyst
    import hc_pkg::*;
#(
    parameter int     W_IN      = 14,
    parameter int     W_TRIG    = 16,
    parameter int     MU_Z1     = 110,
    parameter int     MU_Z2     = 121,
    parameter longint VG        = 240000,
    parameter int     HYST      = 0,
    parameter int     MIN_DWELL = 8,
    parameter int     SIGMA_RST = 1
) (
    input  logic                     i_clock,
    input  logic                     i_RESET,
    input  logic                     i_enable,
    input  logic                     i_valid,
    input  logic signed [W_IN-1:0]   i_vC,
    input  logic signed [W_IN-1:0]   i_iC,
    input  logic signed [W_TRIG-1:0] i_cos,
    input  logic signed [W_TRIG-1:0] i_sin,
    output logic                     o_sigma,
    output logic                     o_switch,
    output logic                     o_locked,
    output logic                     o_valid,
    output logic signed [OUT_W-1:0]  o_jump
);

    localparam int                       SHIFT  = W_TRIG - 2;
    localparam logic signed [Z_W-1:0]    MU1    = Z_W'(MU_Z1);
    localparam logic signed [Z_W-1:0]    MU2    = Z_W'(MU_Z2);
    localparam logic signed [Z_W-1:0]    VG_Z   = Z_W'(VG);
    localparam logic signed [JUMP_W-1:0] HYST_P = JUMP_W'(HYST);
    localparam logic signed [JUMP_W-1:0] HYST_N = -HYST_P;

    logic signed [W_IN-1:0]   r_vc, r_ic;
    logic signed [W_TRIG-1:0] r_cos0, r_sin0, r_cos1, r_sin1;
    logic signed [Z_W-1:0]    r_z1, r_z2;
    logic signed [JUMP_W-1:0] r_jump;
    logic signed [OUT_W-1:0]  r_jump_o;
    logic                     r_v0, r_v1, r_v2, r_valid;

    hc_state_e                w_state;
    logic                     w_sigma, w_run, w_req_pos, w_req_neg;
    logic signed [Z_W-1:0]    w_vc_x, w_ic_x, w_z1, w_z2;
    logic signed [JUMP_W-1:0] w_z1_x, w_z2_x, w_cos_x, w_sin_x, w_jump_full, w_jump_shr;

    // Strobe-only interface, no backpressure: a sample is taken on any clock with
    // i_valid=1 while running, and every accepted sample yields one o_valid 3 clocks later.
    assign w_run = i_enable && (w_state != ST_IDLE);

    assign w_vc_x      = Z_W'(r_vc);
    assign w_ic_x      = Z_W'(r_ic);
    assign w_z1        = MU1 * w_vc_x - (w_sigma ? VG_Z : -VG_Z);
    assign w_z2        = MU2 * w_ic_x;
    assign w_z1_x      = JUMP_W'(r_z1);
    assign w_z2_x      = JUMP_W'(r_z2);
    assign w_cos_x     = JUMP_W'(r_cos1);
    assign w_sin_x     = JUMP_W'(r_sin1);
    assign w_jump_full = w_z1_x * w_sin_x + w_z2_x * w_cos_x;
    assign w_jump_shr  = w_jump_full >>> SHIFT;
    assign w_req_pos   = (r_jump > HYST_P);
    assign w_req_neg   = (r_jump < HYST_N);

    always_ff @(posedge i_clock or negedge i_RESET) begin
        if (!i_RESET) begin
            r_vc     <= '0;
            r_ic     <= '0;
            r_cos0   <= '0;
            r_sin0   <= '0;
            r_cos1   <= '0;
            r_sin1   <= '0;
            r_z1     <= '0;
            r_z2     <= '0;
            r_jump   <= '0;
            r_jump_o <= '0;
            r_v0     <= 1'b0;
            r_v1     <= 1'b0;
            r_v2     <= 1'b0;
            r_valid  <= 1'b0;
        end else begin
            r_v0    <= i_valid & w_run;
            r_v1    <= r_v0 & w_run;
            r_v2    <= r_v1 & w_run;
            r_valid <= r_v2 & w_run;
            if (i_valid) begin
                r_vc   <= i_vC;
                r_ic   <= i_iC;
                r_cos0 <= i_cos;
                r_sin0 <= i_sin;
            end
            r_z1   <= w_z1;
            r_z2   <= w_z2;
            r_cos1 <= r_cos0;
            r_sin1 <= r_sin0;
            r_jump <= w_jump_shr;
            // Debug copy is clamped; the decision above uses the full-width jump.
            if (r_v2 && w_run) begin
                r_jump_o <= sat_jump(r_jump);
            end
        end
    end

    hc_dwell_fsm #(
        .MIN_DWELL (MIN_DWELL),
        .SIGMA_RST (SIGMA_RST)
    ) u_fsm (
        .i_clock     (i_clock),
        .i_RESET     (i_RESET),
        .i_enable    (i_enable),
        .i_dec_valid (r_v2),
        .i_req_pos   (w_req_pos),
        .i_req_neg   (w_req_neg),
        .o_sigma     (w_sigma),
        .o_switch    (o_switch),
        .o_locked    (o_locked),
        .o_state     (w_state)
    );

    assign o_sigma = w_sigma;
    assign o_valid = r_valid;
    assign o_jump  = r_jump_o;

endmodule

// File: tb/tb_hybrid_control_hyst.sv
// Self-checking bench for hybrid_control_hyst: directed scenarios plus random
// traffic, all scored against a sample-level behavioural model.
module tb_hybrid_control_hyst;

    localparam int     W_IN      = 14;
    localparam int     W_TRIG    = 16;
    localparam int     HYST      = 5000;
    localparam int     MIN_DWELL = 8;
    localparam longint VG        = 240000;
    localparam longint VG_SAT    = 64'd68719476736;

    // ---------------- clock / reset / signals ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic en = 1'b0;
    logic en_sat = 1'b0;
    logic vld = 1'b0;
    logic signed [W_IN-1:0]   vc = '0;
    logic signed [W_IN-1:0]   ic = '0;
    logic signed [W_TRIG-1:0] cs = '0;
    logic signed [W_TRIG-1:0] sn = '0;

    logic        sigma, sw, locked, ovalid;
    logic signed [31:0] jump;
    logic        s_sigma, s_sw, s_locked, s_valid;
    logic signed [31:0] s_jump;

    always #5 clk = ~clk;

    hybrid_control_hyst #(
        .W_IN(W_IN), .W_TRIG(W_TRIG), .MU_Z1(110), .MU_Z2(121), .VG(VG),
        .HYST(HYST), .MIN_DWELL(MIN_DWELL), .SIGMA_RST(1)
    ) dut (
        .i_clock(clk), .i_RESET(rst_n), .i_enable(en), .i_valid(vld),
        .i_vC(vc), .i_iC(ic), .i_cos(cs), .i_sin(sn),
        .o_sigma(sigma), .o_switch(sw), .o_locked(locked), .o_valid(ovalid), .o_jump(jump)
    );

    hybrid_control_hyst #(
        .W_IN(W_IN), .W_TRIG(W_TRIG), .MU_Z1(110), .MU_Z2(121), .VG(VG_SAT),
        .HYST(0), .MIN_DWELL(0), .SIGMA_RST(0)
    ) dut_sat (
        .i_clock(clk), .i_RESET(rst_n), .i_enable(en_sat), .i_valid(vld),
        .i_vC(vc), .i_iC(ic), .i_cos(cs), .i_sin(sn),
        .o_sigma(s_sigma), .o_switch(s_sw), .o_locked(s_locked), .o_valid(s_valid), .o_jump(s_jump)
    );

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic signed [63:0] got,
                            input logic signed [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int     age;
        int     vc, ic, c, s;
        longint j;
    } smp_t;

    smp_t   pend_q[$];
    bit     m_active;
    bit     m_sigma;
    longint m_last_tog;
    longint edge_n;
    longint exp_jump;
    bit     exp_valid, exp_sw;

    function automatic longint model_jump(input int a, input int b, input int c, input int s,
                                          input bit sig, input longint vg);
        longint z1, z2, full;
        z1   = 110 * longint'(a) - (sig ? vg : -vg);
        z2   = 121 * longint'(b);
        full = z1 * longint'(s) + z2 * longint'(c);
        return full >>> 14;
    endfunction

    function automatic longint sat32(input longint x);
        if (x > 64'sd2147483647) return 64'sd2147483647;
        if (x < -64'sd2147483648) return -64'sd2147483648;
        return x;
    endfunction

    task automatic model_reset();
        pend_q.delete();
        m_active   = 1'b0;
        m_sigma    = 1'b1;
        m_last_tog = -1000;
        edge_n     = 0;
        exp_jump   = 0;
        exp_valid  = 1'b0;
        exp_sw     = 1'b0;
    endtask

    // One clock edge, evaluated from the inputs and model state in force before it.
    task automatic model_edge();
        bit   sig0;
        smp_t t;
        edge_n++;
        exp_valid = 1'b0;
        exp_sw    = 1'b0;
        if (!en) begin
            m_active   = 1'b0;
            m_sigma    = 1'b1;
            m_last_tog = -1000;
            pend_q.delete();
        end else if (!m_active) begin
            m_active = 1'b1;
        end else begin
            sig0 = m_sigma;
            foreach (pend_q[i]) begin
                t = pend_q[i];
                t.age++;
                if (t.age == 1) t.j = model_jump(t.vc, t.ic, t.c, t.s, sig0, VG);
                pend_q[i] = t;
            end
            if (pend_q.size() > 0 && pend_q[0].age == 3) begin
                t = pend_q.pop_front();
                exp_valid = 1'b1;
                exp_jump  = sat32(t.j);
                if (edge_n - m_last_tog > MIN_DWELL) begin
                    if (sig0 && t.j > HYST) begin
                        m_sigma = 1'b0; exp_sw = 1'b1; m_last_tog = edge_n;
                    end else if (!sig0 && t.j < -HYST) begin
                        m_sigma = 1'b1; exp_sw = 1'b1; m_last_tog = edge_n;
                    end
                end
            end
            if (vld) begin
                t.age = 0; t.vc = vc; t.ic = ic; t.c = cs; t.s = sn; t.j = 0;
                pend_q.push_back(t);
            end
        end
    endtask

    task automatic compare_all();
        check_eq("valid",  ovalid, exp_valid);
        check_eq("sigma",  sigma,  m_sigma);
        check_eq("switch", sw,     exp_sw);
        check_eq("locked", locked, (edge_n - m_last_tog < MIN_DWELL));
        check_eq("jump",   jump,   exp_jump);
    endtask

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
        model_edge();
        compare_all();
    endtask

    task automatic drive(input bit v, input int a, input int b, input int c, input int s);
        vld = v;
        vc  = W_IN'(a);
        ic  = W_IN'(b);
        cs  = W_TRIG'(c);
        sn  = W_TRIG'(s);
        step();
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) drive(1'b0, 0, 0, 0, 0);
    endtask

    task automatic send_wait(input int a, input int b, input int c, input int s, output int lat);
        drive(1'b1, a, b, c, s);
        lat = 0;
        for (int k = 1; k <= 8; k++) begin
            drive(1'b0, 0, 0, 0, 0);
            if (ovalid) begin
                lat = k;
                break;
            end
        end
        if (lat == 0) check_eq("valid_timeout", ovalid, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1);
    end

    // ---------------- stimulus ----------------
    initial begin
        int lat, lcnt, gap, mode, seen;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        check_eq("rst_sigma",  sigma,  1);
        check_eq("rst_valid",  ovalid, 0);
        check_eq("rst_locked", locked, 0);
        check_eq("rst_switch", sw,     0);
        check_eq("rst_jump",   jump,   0);

        // Latency and first toggle: theta=0, iC=+100 -> jump 12100
        en = 1'b1;
        idle(2);
        send_wait(0, 100, 16384, 0, lat);
        check_eq("t2_latency", lat, 3);
        check_eq("t2_jump", jump, 12100);
        check_eq("t2_sigma", sigma, 0);
        check_eq("t2_switch", sw, 1);

        // Dwell: opposite-sign sample every clock right after the toggle
        lcnt = locked ? 1 : 0;
        gap  = 0;
        for (int k = 1; k <= 20; k++) begin
            drive(1'b1, 0, -100, 16384, 0);
            if (sw && gap == 0) gap = k;
            if (gap == 0 && locked) lcnt++;
        end
        check_eq("dwell_gap", gap, MIN_DWELL + 1);
        check_eq("locked_len", lcnt, MIN_DWELL);
        check_eq("dwell_sigma", sigma, 1);
        idle(12);

        // Hysteresis band around +/-5000 including the exact edges
        send_wait(0, 33, 16384, 0, lat);
        check_eq("hyst_p4000_hold", sigma, 1);
        send_wait(0, 42, 16120, 0, lat);
        check_eq("hyst_eq_p_jump", jump, 5000);
        check_eq("hyst_eq_p_hold", sigma, 1);
        send_wait(0, 50, 16384, 0, lat);
        check_eq("hyst_p6000_off", sigma, 0);
        idle(10);
        send_wait(0, -33, 16384, 0, lat);
        check_eq("hyst_n4000_hold", sigma, 0);
        send_wait(0, -42, 16118, 0, lat);
        check_eq("hyst_eq_n_jump", jump, -5000);
        check_eq("hyst_eq_n_hold", sigma, 0);

        // Enable drop while OFF with samples in flight
        drive(1'b1, 0, -100, 16384, 0);
        drive(1'b1, 0, -100, 16384, 0);
        en = 1'b0;
        drive(1'b0, 0, 0, 0, 0);
        check_eq("dis_sigma", sigma, 1);
        check_eq("dis_switch", sw, 0);
        for (int k = 0; k < 4; k++) begin
            drive(1'b0, 0, 0, 0, 0);
            check_eq("dis_no_valid", ovalid, 0);
        end
        en = 1'b1;
        idle(2);

        // Asynchronous reset mid-run while OFF and locked
        send_wait(0, 100, 16384, 0, lat);
        check_eq("pre_rst_sigma", sigma, 0);
        drive(1'b1, 0, 100, 16384, 0);
        #3;
        rst_n = 1'b0;
        #1;
        check_eq("arst_sigma",  sigma,  1);
        check_eq("arst_valid",  ovalid, 0);
        check_eq("arst_locked", locked, 0);
        check_eq("arst_switch", sw,     0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        idle(2);

        // Saturation on the large-VG instance: jump far below -2^31, OFF -> ON
        en_sat = 1'b1;
        idle(2);
        check_eq("sat_start_sigma", s_sigma, 0);
        drive(1'b1, -8192, -8192, 11585, -11585);
        seen = 0;
        for (int k = 1; k <= 6; k++) begin
            drive(1'b0, 0, 0, 0, 0);
            if (s_valid) begin
                seen = k;
                check_eq("sat_jump_min", s_jump, -64'sd2147483648);
                check_eq("sat_jump_model", s_jump,
                         sat32(model_jump(-8192, -8192, 11585, -11585, 1'b0, VG_SAT)));
                check_eq("sat_sigma", s_sigma, 1);
                check_eq("sat_switch", s_sw, 1);
                break;
            end
        end
        check_eq("sat_latency", seen, 3);
        en_sat = 1'b0;

        // Random traffic: near-band and full-range samples, occasional disable
        for (int n = 0; n < 500; n++) begin
            en   = ($urandom_range(0, 49) != 0);
            mode = $urandom_range(0, 3);
            if (mode != 0) begin
                drive(($urandom_range(0, 9) < 7),
                      int'($urandom_range(0, 400)) - 200,
                      int'($urandom_range(0, 120)) - 60,
                      int'($urandom_range(0, 32768)) - 16384,
                      int'($urandom_range(0, 600)) - 300);
            end else begin
                drive(($urandom_range(0, 9) < 7),
                      int'($urandom_range(0, 16383)) - 8192,
                      int'($urandom_range(0, 16383)) - 8192,
                      int'($urandom_range(0, 32768)) - 16384,
                      int'($urandom_range(0, 32768)) - 16384);
            end
        end
        en = 1'b1;
        idle(6);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
